// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_pkg: state encoding and A-H Morse pattern/length tables        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package morse_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ON   = ST_ON,
    S_GAP  = ST_GAP
  } morse_state_t;

  // MSB first, left-aligned; 1 = dash, 0 = dot; unused tail bits are 0
  function automatic logic [3:0] morse_pattern(input logic [2:0] sel);
    logic [3:0] pat;
    case (sel)
      3'd0:    pat = 4'b0100;
      3'd1:    pat = 4'b1000;
      3'd2:    pat = 4'b1010;
      3'd3:    pat = 4'b1000;
      3'd4:    pat = 4'b0000;
      3'd5:    pat = 4'b0010;
      3'd6:    pat = 4'b1100;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] morse_len(input logic [2:0] sel);
    logic [2:0] len;
    case (sel)
      3'd0:    len = 3'd2;
      3'd1:    len = 3'd4;
      3'd2:    len = 3'd4;
      3'd3:    len = 3'd3;
      3'd4:    len = 3'd1;
      3'd5:    len = 3'd4;
      3'd6:    len = 3'd3;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_unit_timer: prescaler + unit counter, expire after N units     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module morse_unit_timer #(
  parameter int TICKS_PER_UNIT = 25_000_000,
  parameter int CNT_W          = 25,
  parameter int UNIT_W         = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [UNIT_W-1:0] units_target,
  output logic              expire
);

  localparam logic [CNT_W-1:0]  C_PRE_LAST = CNT_W'(TICKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [UNIT_W-1:0] C_UNIT_ONE = UNIT_W'(1);

  logic [CNT_W-1:0]  r_prescale;
  logic [UNIT_W-1:0] r_units;
  logic              w_unit_end;

  assign w_unit_end = (r_prescale == C_PRE_LAST);
  assign expire     = !clr && w_unit_end && ((r_units + C_UNIT_ONE) == units_target);

  // Clearing on expire lets the next state start on a fresh unit boundary
  always_ff @(posedge clk) begin
    if (!reset || clr || expire) begin
      r_prescale <= '0;
      r_units    <= '0;
    end else if (w_unit_end) begin
      r_prescale <= '0;
      r_units    <= r_units + C_UNIT_ONE;
    end else begin
      r_prescale <= r_prescale + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/morse_letter_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_letter_transmitter: plays latched A-H Morse letter on led      |
// | Option: MORSE_REPEAT_EN - held load repeats the letter after done    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module morse_letter_transmitter
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 25_000_000,
  parameter int CNT_W          = 25,
  parameter int DASH_UNITS     = 3,
  parameter int GAP_UNITS      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] select,
  input  logic       load,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [2:0] size
);

  localparam int C_UNIT_MAX = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int C_UNIT_W   = $clog2(C_UNIT_MAX + 1);

  localparam logic [C_UNIT_W-1:0] C_DOT_T  = C_UNIT_W'(1);
  localparam logic [C_UNIT_W-1:0] C_DASH_T = C_UNIT_W'(DASH_UNITS);
  localparam logic [C_UNIT_W-1:0] C_GAP_T  = C_UNIT_W'(GAP_UNITS);

  morse_state_t        r_state;
  logic [3:0]          r_pattern;
  logic [2:0]          r_remaining;
  logic [2:0]          r_size;
  logic                r_load_q;
  logic                r_led;
  logic                r_busy;
  logic                r_done;

  logic                w_start;
  logic                w_expire;
  logic                w_tmr_clr;
  logic [C_UNIT_W-1:0] w_target;

`ifdef MORSE_REPEAT_EN
  assign w_start = (r_state == S_IDLE) && load && (!r_load_q || r_done);
`else
  assign w_start = (r_state == S_IDLE) && load && !r_load_q;
`endif

  // Timer held cleared in IDLE so ON always begins at a zero count
  assign w_tmr_clr = (r_state == S_IDLE);

  always_comb begin
    w_target = C_DOT_T;
    case (r_state)
      S_GAP:   w_target = C_GAP_T;
      S_ON:    w_target = r_pattern[3] ? C_DASH_T : C_DOT_T;
      default: w_target = C_DOT_T;
    endcase
  end

  morse_unit_timer #(
    .TICKS_PER_UNIT (TICKS_PER_UNIT),
    .CNT_W          (CNT_W),
    .UNIT_W         (C_UNIT_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clr          (w_tmr_clr),
    .units_target (w_target),
    .expire       (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pattern   <= '0;
      r_remaining <= '0;
      r_size      <= '0;
      r_load_q    <= 1'b1;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_load_q <= load;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_ON;
            r_pattern   <= morse_pattern(select);
            r_size      <= morse_len(select);
            r_remaining <= morse_len(select);
            r_led       <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_ON: begin
          if (w_expire) begin
            r_state <= S_GAP;
            r_led   <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_expire) begin
            r_pattern   <= {r_pattern[2:0], 1'b0};
            r_remaining <= r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ON;
              r_led   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;
  assign size = r_size;

endmodule
`default_nettype wire

// File: tb/tb_morse_letter_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_morse_letter_transmitter: waveform-queue model, random + directed |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_morse_letter_transmitter;

  localparam int T     = 2;
  localparam int CNT_W = 2;
  localparam int DASH  = 3;
  localparam int GAP   = 1;
`ifdef MORSE_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [2:0] select = 3'd0;
  logic       led, busy, done;
  logic [2:0] size;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  morse_letter_transmitter #(
    .TICKS_PER_UNIT (T),
    .CNT_W          (CNT_W),
    .DASH_UNITS     (DASH),
    .GAP_UNITS      (GAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .load   (load),
    .led    (led),
    .busy   (busy),
    .done   (done),
    .size   (size)
  );

  function automatic string code_of(input logic [2:0] s);
    case (s)
      3'd0: return ".-";
      3'd1: return "-...";
      3'd2: return "-.-.";
      3'd3: return "-..";
      3'd4: return ".";
      3'd5: return "..-.";
      3'd6: return "--.";
      default: return "....";
    endcase
  endfunction

  typedef struct packed {logic led; logic busy; logic done;} exp_t;
  exp_t       q[$];
  exp_t       cur = '0;
  logic [2:0] m_size = 3'd0;
  logic       m_load_q = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs come from the dot/dash string of the letter
  task automatic build(input logic [2:0] s);
    string c;
    int    units;
    c = code_of(s);
    for (int i = 0; i < c.len(); i++) begin
      units = (c[i] == "-") ? DASH : 1;
      for (int k = 0; k < units * T; k++) q.push_back(exp_t'(3'b110));
      for (int k = 0; k < GAP * T; k++)   q.push_back(exp_t'(3'b010));
    end
    q.push_back(exp_t'(3'b001));
  endtask

  always @(posedge clk) begin : model
    bit start;
    if (!reset) begin
      q.delete();
      cur      = '0;
      m_size   = 3'd0;
      m_load_q = 1'b1;
    end else begin
      start = !cur.busy && load && (!m_load_q || (REPEAT && cur.done));
      if (start) begin
        build(select);
        m_size = 3'(code_of(select).len());
      end
      cur      = (q.size() > 0) ? q.pop_front() : exp_t'(3'b000);
      m_load_q = load;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("led",  {31'd0, led},  {31'd0, cur.led});
      check("busy", {31'd0, busy}, {31'd0, cur.busy});
      check("done", {31'd0, done}, {31'd0, cur.done});
      check("size", {29'd0, size}, {29'd0, m_size});
    end
  end

  // Plays one letter; optionally pulses load with a new select mid-letter
  task automatic play(input logic [2:0] s, input bit disturb,
                      output int nbusy, output logic [31:0] trace, output int ndone);
    bit fin;
    nbusy = 0; trace = '0; ndone = 0; fin = 1'b0;
    @(negedge clk); select = s; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (busy) begin
        nbusy++;
        trace = {trace[30:0], led};
      end
      if (done) begin
        ndone++;
        fin = 1'b1;
      end
      if (disturb && nbusy == 5) begin select = 3'd0; load = 1'b1; end
      if (disturb && nbusy == 6) load = 1'b0;
      if (!fin) @(negedge clk);
    end
    if (!fin) check("play_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin : stim
    int          nb, nd;
    logic [31:0] tr;
    bit          fin;

    // 1: key held through reset must not start a letter
    reset = 1'b0; load = 1'b1;
    @(posedge clk); #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_led",  {31'd0, led},  32'd0);
    check("rst_size", {29'd0, size}, 32'd0);
    load = 1'b0;
    repeat (2) @(negedge clk);

    // 2/3: A, H, E
    play(3'd0, 1'b0, nb, tr, nd);
    check("A_busy", nb, 12); check("A_led", tr, 32'h0000_0CFC); check("A_done", nd, 1);
    check("A_size", {29'd0, size}, 32'd2);
    play(3'd7, 1'b0, nb, tr, nd);
    check("H_busy", nb, 16); check("H_led", tr, 32'h0000_CCCC); check("H_size", {29'd0, size}, 32'd4);
    play(3'd4, 1'b0, nb, tr, nd);
    check("E_busy", nb, 4); check("E_led", tr, 32'h0000_000C); check("E_size", {29'd0, size}, 32'd1);

    // 4: C with mid-letter select change and load pulse
    play(3'd2, 1'b1, nb, tr, nd);
    check("C_busy", nb, 24); check("C_led", tr, 32'h00FC_CFCC); check("C_size", {29'd0, size}, 32'd4);
    repeat (3) @(negedge clk);

    // 5: B aborted by reset during second symbol
    select = 3'd1; load = 1'b1;
    @(negedge clk); load = 1'b0;
    nb = 0; nd = 0;
    for (int c = 0; c < 50 && nb < 9; c++) begin
      if (busy) nb++;
      if (done) nd++;
      if (nb < 9) @(negedge clk);
    end
    check("B_reached_sym2", nb, 9);
    reset = 1'b0;
    @(negedge clk);
    check("abort_led",  {31'd0, led},  32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_size", {29'd0, size}, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("abort_no_done", nd, 0);

    // 6: E with load held high
    select = 3'd4; load = 1'b1;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("hold_done_count", nd, REPEAT ? 4 : 1);
    load = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (!busy && !done) fin = 1'b1;
    end
    if (!fin) check("hold_idle_timeout", 32'd0, 32'd1);

    // Random traffic: load, select and occasional reset checked by the model
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      load   = ($urandom_range(0, 3) == 0);
      select = 3'($urandom_range(0, 7));
      reset  = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1; load = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
